// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, request/acknowledge instruction fetch with timeout,
// instruction register and combinational field decode for the control unit.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [7:0]  TIMEOUT  = 8'd15
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Fetch,
   input  logic        PCWrite,
   input  logic [15:0] PCIn,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [15:0] IMemData,
   output logic [4:0]  OPCODE,
   output logic        flagbit,
   output logic [9:0]  Immediate,
   output logic        InstrValid,
   output logic [15:0] PC,
   output logic        FetchErr
);

   // state | meaning
   // IDLE  | waiting for Fetch; PCWrite loads PC
   // REQ   | memory request outstanding at PC; counting wait cycles
   // ERR   | memory never acked; held until PCWrite or reset
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc_q, pc_next;
   logic [15:0] ir_q, ir_next;
   logic [7:0]  cnt_q, cnt_next;
   logic        valid_q, valid_next;
   logic        err_q, err_next;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pc_q    <= RESET_PC;
         ir_q    <= 16'h0000;
         cnt_q   <= 8'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_next;
         ir_q    <= ir_next;
         cnt_q   <= cnt_next;
         valid_q <= valid_next;
         err_q   <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc_q;
      ir_next    = ir_q;
      cnt_next   = cnt_q;
      valid_next = 1'b0;
      err_next   = err_q;
      case (state)
         IDLE: begin
            if (PCWrite) pc_next = PCIn;
            if (Fetch) begin
               state_next = REQ;
               cnt_next   = 8'd0;
            end
         end
         REQ: begin
            // redirect beats a same-cycle ack, and an ack beats the timeout
            if (PCWrite) begin
               pc_next    = PCIn;
               state_next = IDLE;
            end else if (IMemAck) begin
               ir_next    = IMemData;
               pc_next    = pc_q + 16'd1;
               valid_next = 1'b1;
               state_next = IDLE;
            end else if (cnt_q == TIMEOUT) begin
               err_next   = 1'b1;
               state_next = ERR;
            end else begin
               cnt_next = cnt_q + 8'd1;
            end
         end
         ERR: begin
            if (PCWrite) begin
               pc_next    = PCIn;
               err_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign IMemReq    = (state == REQ);
   assign IMemAddr   = pc_q;
   assign PC         = pc_q;
   assign InstrValid = valid_q;
   assign FetchErr   = err_q;
   assign OPCODE     = ir_q[15:11];
   assign flagbit    = ir_q[10];
   assign Immediate  = ir_q[9:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus randomized fetch,
// redirect and abort traffic checked against a transaction-level PC/IR model.
module tb_instr_fetch_unit;

   localparam logic [15:0] RPC = 16'h0000;
   localparam int          TO  = 15;

   logic        CLK, Reset, Fetch, PCWrite, IMemReq, IMemAck, flagbit, InstrValid, FetchErr;
   logic [15:0] PCIn, IMemAddr, IMemData, PC;
   logic [4:0]  OPCODE;
   logic [9:0]  Immediate;

   instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(8'(TO))) dut (
      .CLK(CLK), .Reset(Reset), .Fetch(Fetch), .PCWrite(PCWrite), .PCIn(PCIn),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
      .OPCODE(OPCODE), .flagbit(flagbit), .Immediate(Immediate),
      .InstrValid(InstrValid), .PC(PC), .FetchErr(FetchErr)
   );

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] model_pc;
   logic [15:0] last_ir;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // every InstrValid must match the oldest completed fetch issued by the stimulus
   always @(negedge CLK) begin
      if (InstrValid === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got InstrValid=1 expected no pending fetch");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_opcode", 32'(OPCODE), 32'(e.ir[15:11]));
            chk("mon_flag", 32'(flagbit), 32'(e.ir[10]));
            chk("mon_imm", 32'(Immediate), 32'(e.ir[9:0]));
            chk("mon_pc", 32'(PC), 32'(e.pc));
         end
      end
   end

   // waits = REQ cycles before the ack cycle; optional redirect issued together with Fetch
   task automatic fetch_op(input int waits, input logic [15:0] data,
                           input bit redir, input logic [15:0] target);
      exp_t e;
      Fetch = 1'b1;
      if (redir) begin
         PCWrite = 1'b1;
         PCIn    = target;
      end
      step();
      Fetch   = 1'b0;
      PCWrite = 1'b0;
      if (redir) model_pc = target;
      chk("req_addr", 32'(IMemAddr), 32'(model_pc));
      for (int i = 0; i < waits; i++) begin
         chk("req_high", 32'(IMemReq), 32'd1);
         step();
      end
      chk("req_high_ack", 32'(IMemReq), 32'd1);
      IMemAck  = 1'b1;
      IMemData = data;
      model_pc = model_pc + 16'd1;
      last_ir  = data;
      e.ir     = data;
      e.pc     = model_pc;
      sb.push_back(e);
      step();
      IMemAck = 1'b0;
      chk("req_low_after", 32'(IMemReq), 32'd0);
      chk("no_err", 32'(FetchErr), 32'd0);
   endtask

   task automatic abort_op(input int waits, input logic [15:0] target);
      Fetch = 1'b1;
      step();
      Fetch = 1'b0;
      repeat (waits) step();
      PCWrite  = 1'b1;
      PCIn     = target;
      IMemAck  = 1'b1;
      IMemData = 16'($urandom);
      step();
      PCWrite  = 1'b0;
      IMemAck  = 1'b0;
      model_pc = target;
      chk("abort_req", 32'(IMemReq), 32'd0);
      chk("abort_pc", 32'(PC), 32'(target));
      chk("abort_valid", 32'(InstrValid), 32'd0);
      chk("abort_ir", 32'({OPCODE, flagbit, Immediate}), 32'(last_ir));
   endtask

   initial begin
      Reset = 1'b0; Fetch = 1'b0; PCWrite = 1'b0; PCIn = 16'h0;
      IMemAck = 1'b0; IMemData = 16'h0;
      model_pc = RPC;
      last_ir  = 16'h0;
      repeat (2) step();
      chk("rst_pc", 32'(PC), 32'(RPC));
      chk("rst_ir", 32'({OPCODE, flagbit, Immediate}), 32'd0);
      chk("rst_req", 32'(IMemReq), 32'd0);
      chk("rst_valid", 32'(InstrValid), 32'd0);
      chk("rst_err", 32'(FetchErr), 32'd0);
      Reset = 1'b1;
      step();

      // zero-wait fetch
      fetch_op(0, 16'h5C2A, 1'b0, 16'h0);
      chk("t1_opcode", 32'(OPCODE), 32'h0B);
      chk("t1_flag", 32'(flagbit), 32'd1);
      chk("t1_imm", 32'(Immediate), 32'h02A);
      chk("t1_pc", 32'(PC), 32'd1);
      chk("t1_valid", 32'(InstrValid), 32'd1);

      // three REQ cycles
      fetch_op(2, 16'h0000, 1'b0, 16'h0);
      chk("t2_opcode", 32'(OPCODE), 32'd0);
      chk("t2_flag", 32'(flagbit), 32'd0);
      step();
      chk("t2_valid_once", 32'(InstrValid), 32'd0);

      // redirect together with Fetch
      fetch_op(1, 16'hA3C1, 1'b1, 16'h0040);
      chk("t3_pc", 32'(PC), 32'h0041);

      // abort with a simultaneous ack
      abort_op(1, 16'h0100);
      step();
      chk("t4_idle", 32'(IMemReq), 32'd0);

      // wrap
      PCWrite = 1'b1; PCIn = 16'hFFFF;
      step();
      PCWrite = 1'b0;
      model_pc = 16'hFFFF;
      fetch_op(1, 16'h1234, 1'b0, 16'h0);
      chk("t5_wrap", 32'(PC), 32'h0000);

      // ack in the last allowed cycle completes normally
      fetch_op(TO, 16'h7E55, 1'b0, 16'h0);

      // timeout
      Fetch = 1'b1;
      step();
      Fetch = 1'b0;
      for (int i = 0; i < TO + 1; i++) begin
         chk("to_req", 32'(IMemReq), 32'd1);
         chk("to_noerr", 32'(FetchErr), 32'd0);
         step();
      end
      chk("to_err", 32'(FetchErr), 32'd1);
      chk("to_req_low", 32'(IMemReq), 32'd0);
      Fetch = 1'b1;
      repeat (3) begin
         step();
         chk("err_ignores_fetch", 32'(IMemReq), 32'd0);
         chk("err_sticky", 32'(FetchErr), 32'd1);
      end
      Fetch = 1'b0;
      PCWrite = 1'b1; PCIn = 16'h0200;
      step();
      PCWrite = 1'b0;
      model_pc = 16'h0200;
      chk("err_clear", 32'(FetchErr), 32'd0);
      chk("err_pc", 32'(PC), 32'h0200);

      // async reset mid-REQ
      Fetch = 1'b1;
      step();
      Fetch = 1'b0;
      #2;
      Reset = 1'b0;
      #1;
      chk("ar_req", 32'(IMemReq), 32'd0);
      chk("ar_pc", 32'(PC), 32'(RPC));
      IMemAck = 1'b1; IMemData = 16'hFFFF;
      repeat (2) step();
      chk("ar_ir", 32'({OPCODE, flagbit, Immediate}), 32'd0);
      chk("ar_valid", 32'(InstrValid), 32'd0);
      IMemAck = 1'b0;
      Reset = 1'b1;
      model_pc = RPC;
      last_ir  = 16'h0;
      step();
      fetch_op(0, 16'h0C03, 1'b0, 16'h0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(0, 5);
         if (r == 0)
            abort_op($urandom_range(0, 4), 16'($urandom));
         else
            fetch_op($urandom_range(0, 6), 16'($urandom), r == 1, 16'($urandom));
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (3) step();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage ahead of `control_unit`: holds the program counter, runs a request/acknowledge fetch against instruction memory, and latches the returned word into an instruction register. It decodes the latched word into `OPCODE`, `flagbit` and `Immediate`, and signals `InstrValid` so the control unit starts its sequence on a stable instruction. Datapath redirects (jumps, function calls) arrive through `PCWrite`/`PCIn`.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `TIMEOUT`, 8'd15, REQ cycles without ack before a fetch error (legal 1..255)
- `CLK`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Fetch`  in  1  control unit requests the next instruction; sampled in IDLE only
- `PCWrite`  in  1  load PC from `PCIn` (redirect)
- `PCIn`  in  16  redirect target (word address)
- `IMemReq`  out  1  instruction memory request
- `IMemAddr`  out  16  fetch address; always equals PC
- `IMemAck`  in  1  memory data valid this cycle; only meaningful while `IMemReq`=1
- `IMemData`  in  16  instruction word
- `OPCODE`  out  5  IR[15:11]
- `flagbit`  out  1  IR[10] ("@" variant select)
- `Immediate`  out  10  IR[9:0]
- `InstrValid`  out  1  one-cycle pulse: IR was just loaded
- `PC`  out  16  address of the next fetch
- `FetchErr`  out  1  sticky fetch-timeout flag

## Operation
- State machine has three states: IDLE, REQ and ERR. Reset state is IDLE.
- IDLE:
  - `Fetch`=1 moves to REQ.
  - `PCWrite`=1 loads PC<=PCIn.
  - If both are asserted, the PC loads and the fetch proceeds at the new PC.
- REQ:
  - `IMemReq`=1 and `IMemAddr`=PC.
  - On `IMemAck`=1: IR<=IMemData, PC<=PC+1 (16-bit, 16'hFFFF wraps to 16'h0000), `InstrValid`<=1 for one cycle, then return to IDLE.
  - `Fetch` is ignored in REQ.
- Redirect during REQ: `PCWrite`=1 aborts the fetch.
  - PC<=PCIn and the state returns to IDLE.
  - An `IMemAck` in the same cycle is discarded: IR is unchanged and no `InstrValid`.
  - `PCWrite` has priority over `IMemAck`.
  - The memory tolerates `IMemReq` being withdrawn before ack.
- Timeout:
  - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches `TIMEOUT`, the next edge sets `FetchErr`<=1 and moves to ERR with `IMemReq`=0.
  - An ack in the same cycle the counter reaches `TIMEOUT` wins: normal completion, no error.
- ERR:
  - `Fetch` is ignored.
  - `PCWrite`=1 loads PC, clears `FetchErr` and moves to IDLE.
  - Otherwise the block stays in ERR until reset.
- Decode outputs are combinational from IR and hold the last instruction between fetches.
  - The control unit must qualify them with `InstrValid` or its own sequencing.
- Reset mid-fetch: immediate return to IDLE, `IMemReq` drops asynchronously, and any in-flight ack is lost.

## Timing
- Reset values:
  - PC=`RESET_PC`, IR=16'h0000, so `OPCODE`=0, `flagbit`=0, `Immediate`=0.
  - `IMemReq`=0, `InstrValid`=0, `FetchErr`=0, counter=0.
- `Fetch` is sampled at edge n. `IMemReq` is high from cycle n+1.
- Ack in cycle k: IR, the decode outputs, PC+1 and `InstrValid` are all visible in cycle k+1.
- Minimum `Fetch`-to-`InstrValid` latency is 2 cycles (zero-wait memory acking in the first REQ cycle).
- A new `Fetch` asserted in the `InstrValid` cycle is accepted: back-to-back fetches issue every 2 cycles.
- Timeout: with no ack, `FetchErr` rises `TIMEOUT`+1 cycles after REQ entry.
- `PCWrite` takes effect on the next edge in every state. `IMemAddr` follows PC with no extra delay.
- All outputs are registered except the decode fields (IR slices) and `IMemAddr` (PC).

## Test plan
- Reset then zero-wait fetch:
  - Stimulus: release `Reset`, pulse `Fetch`, memory acks 16'h5C2A in the first REQ cycle.
  - Required: `IMemAddr`=0; `InstrValid` pulses one cycle; `OPCODE`=5'b01011, `flagbit`=1, `Immediate`=10'h02A; PC=1.
- Wait states:
  - Stimulus: ack after 3 REQ cycles with data 16'h0000.
  - Required: `IMemReq` high exactly 3 cycles; `InstrValid` follows the ack cycle; `OPCODE`=0, `flagbit`=0; no `FetchErr`.
- Redirect:
  - Stimulus: in IDLE, assert `PCWrite` with `PCIn`=16'h0040 together with `Fetch`.
  - Required: the next REQ shows `IMemAddr`=16'h0040; after ack PC=16'h0041.
- Abort:
  - Stimulus: `PCWrite`=1 (`PCIn`=16'h0100) in the same cycle as `IMemAck`.
  - Required: IR is unchanged, no `InstrValid`, PC=16'h0100, state IDLE.
- Wrap and timeout:
  - Stimulus 1: PC=16'hFFFF, fetch with ack. Required: PC=16'h0000.
  - Stimulus 2: next fetch, no ack for `TIMEOUT`=15. Required: `FetchErr`=1 and `IMemReq`=0 after 16 REQ cycles; `Fetch` is then ignored; `PCWrite` clears `FetchErr`.
- Async reset:
  - Stimulus: assert `Reset` low mid-REQ, between edges.
  - Required: `IMemReq` drops immediately and PC=`RESET_PC`; an ack during reset is ignored.
